rc_node_mac_filter: RTL
=======================

# rc_node_mac_filter

Parametrised first-order discrete RC-node model for the audio path. It computes a new node voltage on every `audio_clk_en` as a weighted sum of its previous state, N input voltages and a constant supply term, then scales the state to a normalised output. It replaces hand-generated single-node filters with one time-multiplexed block that uses one multiplier. Instances sit between the sound-board logic sources and the mixer, one per analog node.

## Interface
- `NUM_INPUTS`, 2: number of input voltages, ≥1.
- `WIDTH`, 16: signed width of inputs, state and output.
- `COEF_W`, 16: signed coefficient width.
- `COEF_FRAC`, 12: fractional bits of all coefficients.
- `A_COEF`, 4091: feedback coefficient on the state.
- `B_COEF`, '{2169, 3615}: per-input coefficients, array of `NUM_INPUTS`.
- `BIAS`, 0: constant term (supply contribution), `WIDTH`-bit signed, same Q format as the state.
- `OUT_GAIN`, 4096: output scale coefficient.
- `clk`, in, 1: clock.
- `I_RSTn`, in, 1: reset, synchronous, active-low.
- `audio_clk_en`, in, 1: sample strobe; starts one update.
- `state_clr`, in, 1: synchronous clear of the node state.
- `in_bus`, in, `NUM_INPUTS*WIDTH`: packed signed inputs; input i is at bits [i*WIDTH +: WIDTH].
- `v_out`, out, `WIDTH`: signed scaled node voltage.
- `out_valid`, out, 1: one-cycle pulse when `v_out` updates.
- `busy`, out, 1: FSM not IDLE.
- `sat_flag`, out, 1: sticky; a state or output saturation occurred.
- `overrun`, out, 1: sticky; a strobe arrived while busy.

## Operation
- FSM states: IDLE, MAC, SCALE, OUT.
- IDLE + `audio_clk_en` → MAC. `in_bus` is captured into input registers, the term index k is set to 0 and the accumulator is cleared.
- MAC runs one product per cycle into the accumulator:
  - k=0: `A_COEF*state_q`.
  - k=1..N: `B_COEF[k-1]*in_cap[k-1]`.
  - After k=N → SCALE.
- SCALE:
  - Compute `acc + (BIAS << COEF_FRAC)`, arithmetic-shift right by `COEF_FRAC` with round-half-up (add 2^(COEF_FRAC-1) before the shift).
  - Saturate to `WIDTH` signed and write the result to `state_q`.
  - The multiplier computes `OUT_GAIN*state_next`. → OUT.
- OUT: apply the same round/shift/saturate, register the result into `v_out`, pulse `out_valid`. → IDLE.
- Accumulator width is `WIDTH+COEF_W+$clog2(NUM_INPUTS+2)`. Internal overflow is impossible; saturation happens only at the WIDTH narrowing.
- `sat_flag` is set whenever SCALE or OUT clamps. It clears only on reset.
- `audio_clk_en` while `busy`: the strobe is ignored, `overrun` is set (sticky until reset), and the current update continues unaffected.
- `state_clr` in any state:
  - `state_q` and `v_out` go to 0 and the FSM goes to IDLE.
  - An in-progress update is aborted with no `out_valid`.
  - It overrides a same-cycle `audio_clk_en`.
- Priority: reset > `state_clr` > `audio_clk_en`.

## Timing
- Reset values: `state_q`=0, `v_out`=0, `out_valid`=0, `busy`=0, `sat_flag`=0, `overrun`=0, FSM in IDLE.
- Strobe sampled at edge E0. MAC occupies edges E0+1..E0+N+1. `state_q` updates at E0+N+2. `v_out` and `out_valid` update at E0+N+3.
- Latency is `NUM_INPUTS+3` cycles. Minimum strobe spacing is `NUM_INPUTS+3`; a strobe coincident with the `out_valid` cycle is accepted.
- `busy` is high from E0+1 through E0+N+3 inclusive.
- `in_bus` may change freely after E0.

## Structure
- Package `discrete_pkg`: Q-format helpers (`round_shift`, `sat_to_width` functions), FSM state enum, default coefficient localparams.
- One sub-module, `sat_round_shift`, is reused for the SCALE and OUT narrowing. It is parametrised on in/out width and shift.
- The single signed multiplier is shared across MAC and SCALE via an operand mux driven by the FSM.

## Test plan
- Reset → `v_out`=0, all flags 0. A strobe with all inputs 0 and `BIAS`=0 gives `v_out`=0 and `out_valid` at exactly E0+5 (N=2).
- Impulse: defaults, in0=4096, in1=0, one strobe → `state_q`=2169, `v_out`=2169. Next strobe with inputs 0 → state=(4091*2169+2048)>>12=2166.
- Saturation: `B_COEF`={8192,0}, in0=32767 → `v_out`=32767 and `sat_flag`=1. Negative case in0=-32768 → -32768.
- Rounding: `A_COEF`=2048, state=3, inputs 0 → state=2 (1.5 rounds up). State=-3 → -1 (-1.5 rounds to -1).
- Overrun: strobe at E0 and again at E0+2 → `overrun`=1, exactly one `out_valid`, result identical to a single strobe.
- Clear mid-update: `state_clr` at E0+2 → no `out_valid`, `v_out`=0, `busy`=0 next cycle. A later strobe processes normally from state 0.

Source files
------------

// File: rtl/discrete_pkg.sv
// Shared Q-format helpers, FSM encoding and default coefficients for the
// discrete analog-node models.
package discrete_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } rc_state_e;

  localparam int DEF_NUM_INPUTS = 2;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_COEF_W     = 16;
  localparam int DEF_COEF_FRAC  = 12;
  localparam int DEF_A_COEF     = 4091;
  localparam int DEF_B_COEF [DEF_NUM_INPUTS] = '{2169, 3615};
  localparam int DEF_OUT_GAIN   = 4096;

  // Helpers work on a 64-bit signed carrier; callers keep operands well below that.
  localparam int QW = 64;

  // Arithmetic shift right by sh with round-half-up (sh >= 1).
  function automatic logic signed [QW-1:0] round_shift(input logic signed [QW-1:0] x,
                                                       input int sh);
    logic signed [QW-1:0] half;
    half = 64'sd1 <<< (sh - 1);
    return (x + half) >>> sh;
  endfunction

  // Clamp x to the range of a w-bit two's complement number.
  function automatic logic signed [QW-1:0] sat_to_width(input logic signed [QW-1:0] x,
                                                        input int w);
    logic signed [QW-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/sat_round_shift.sv
// Narrowing stage: round-half-up shift followed by signed saturation.
// Reports whether the clamp engaged.
module sat_round_shift
  import discrete_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int OUT_W = 16,
  parameter int SHIFT = 12
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  logic signed [QW-1:0] wide, rs, cl;

  always_comb begin
    wide = QW'(din);
    rs   = round_shift(wide, SHIFT);
    cl   = sat_to_width(rs, OUT_W);
    dout = OUT_W'(cl);
    sat  = (cl != rs);
  end

endmodule

// File: rtl/rc_node_mac_filter.sv
// First-order discrete RC node: state' = A*state + sum(B_i*in_i) + BIAS,
// evaluated serially through one shared multiplier, then scaled by OUT_GAIN.
module rc_node_mac_filter
  import discrete_pkg::*;
#(
  parameter int                      NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int                      WIDTH      = DEF_WIDTH,
  parameter int                      COEF_W     = DEF_COEF_W,
  parameter int                      COEF_FRAC  = DEF_COEF_FRAC,
  parameter int                      A_COEF     = DEF_A_COEF,
  parameter int                      B_COEF [NUM_INPUTS] = DEF_B_COEF,
  parameter logic signed [WIDTH-1:0] BIAS       = '0,
  parameter int                      OUT_GAIN   = DEF_OUT_GAIN
) (
  input  logic                          clk,
  input  logic                          I_RSTn,
  input  logic                          audio_clk_en,
  input  logic                          state_clr,
  input  logic [NUM_INPUTS*WIDTH-1:0]   in_bus,
  output logic signed [WIDTH-1:0]       v_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          sat_flag,
  output logic                          overrun
);

  localparam int PROD_W = WIDTH + COEF_W;
  localparam int ACC_W  = WIDTH + COEF_W + $clog2(NUM_INPUTS + 2);
  localparam int KW     = (NUM_INPUTS < 1) ? 1 : $clog2(NUM_INPUTS + 1);

  localparam logic signed [COEF_W-1:0] A_C     = COEF_W'(A_COEF);
  localparam logic signed [COEF_W-1:0] G_C     = COEF_W'(OUT_GAIN);
  localparam logic signed [ACC_W-1:0]  BIAS_SH = ACC_W'(BIAS) <<< COEF_FRAC;

  rc_state_e                        st_q, st_d;
  logic [KW-1:0]                    k_q, k_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] in_cap_q, in_cap_d;
  logic signed [WIDTH-1:0]          state_q, state_d;
  logic signed [WIDTH-1:0]          v_out_q, v_out_d;
  logic                             out_valid_q, out_valid_d;
  logic                             sat_flag_q, sat_flag_d;
  logic                             overrun_q, overrun_d;

  logic signed [COEF_W-1:0] mul_a;
  logic signed [WIDTH-1:0]  mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  srs_in;
  logic signed [WIDTH-1:0]  srs_out;
  logic                     srs_sat;
  logic                     start;

  // SCALE folds the supply term in before narrowing; OUT narrows the gain product as-is.
  assign srs_in = (st_q == ST_SCALE) ? (acc_q + BIAS_SH) : acc_q;

  sat_round_shift #(
    .IN_W  (ACC_W),
    .OUT_W (WIDTH),
    .SHIFT (COEF_FRAC)
  ) u_narrow (
    .din  (srs_in),
    .dout (srs_out),
    .sat  (srs_sat)
  );

  // Operand mux: term k of the MAC sequence, or OUT_GAIN*state_next during SCALE.
  always_comb begin
    mul_a = A_C;
    mul_b = state_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (k_q == KW'(i + 1)) begin
        mul_a = COEF_W'(B_COEF[i]);
        mul_b = in_cap_q[i];
      end
    end
    if (st_q == ST_SCALE) begin
      mul_a = G_C;
      mul_b = srs_out;
    end
  end

  assign prod = PROD_W'(mul_a) * PROD_W'(mul_b);

  // A strobe landing on the OUT cycle starts the next update back-to-back.
  assign start = audio_clk_en && ((st_q == ST_IDLE) || (st_q == ST_OUT));

  always_comb begin
    st_d        = st_q;
    k_d         = k_q;
    acc_d       = acc_q;
    in_cap_d    = in_cap_q;
    state_d     = state_q;
    v_out_d     = v_out_q;
    out_valid_d = 1'b0;
    sat_flag_d  = sat_flag_q;
    overrun_d   = overrun_q;

    unique case (st_q)
      ST_IDLE: ;
      ST_MAC: begin
        overrun_d = overrun_q | audio_clk_en;
        acc_d     = acc_q + ACC_W'(prod);
        if (k_q == KW'(NUM_INPUTS)) st_d = ST_SCALE;
        else                        k_d  = k_q + KW'(1);
      end
      ST_SCALE: begin
        overrun_d  = overrun_q | audio_clk_en;
        state_d    = srs_out;
        sat_flag_d = sat_flag_q | srs_sat;
        acc_d      = ACC_W'(prod);
        st_d       = ST_OUT;
      end
      ST_OUT: begin
        v_out_d     = srs_out;
        sat_flag_d  = sat_flag_q | srs_sat;
        out_valid_d = 1'b1;
        st_d        = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase

    if (start) begin
      st_d     = ST_MAC;
      k_d      = '0;
      acc_d    = '0;
      in_cap_d = in_bus;
    end

    // Clear aborts everything in flight, including that cycle's flag updates.
    if (state_clr) begin
      st_d        = ST_IDLE;
      state_d     = '0;
      v_out_d     = '0;
      out_valid_d = 1'b0;
      sat_flag_d  = sat_flag_q;
      overrun_d   = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      st_q        <= ST_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      in_cap_q    <= '0;
      state_q     <= '0;
      v_out_q     <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      in_cap_q    <= in_cap_d;
      state_q     <= state_d;
      v_out_q     <= v_out_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
      overrun_q   <= overrun_d;
    end
  end

  assign v_out     = v_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (st_q != ST_IDLE);
  assign sat_flag  = sat_flag_q;
  assign overrun   = overrun_q;

endmodule
